led_scan_pwm: RTL and testbench

Row-multiplexed scan driver for the 8×8 light-pen LED matrix, directly downstream of the display RAM. Walks rows 0..7, fetches eight 4-bit pixel values per row over the RAM's one-hot read address (registered, 1-cycle read latency), and drives the matrix row/column lines with 16-level per-pixel PWM. Emits a frame strobe and the current scan row so the light-pen detector can correlate pen pulses with the lit row.

---
 rtl/led_scan_pwm_pkg.sv | 34 +++
 rtl/led_scan_pwm_col_cmp.sv | 19 +
 rtl/led_scan_pwm.sv | 148 ++++++++++++++
 tb/tb_led_scan_pwm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pwm_pkg.sv
// Shared scan-driver parameters and state encoding.
// Debug logic decodes scan_state_t from here.
package led_scan_pwm_pkg;

    localparam int SCAN_ROWS        = 8;
    localparam int SCAN_COLS        = 8;
    localparam int PWM_LEVELS       = 16;
    localparam int SLOT_CYCLES_DEF  = 64;
    localparam int BLANK_CYCLES_DEF = 8;

    localparam int ROW_W  = 3;
    localparam int PIX_W  = 4;
    localparam int SLOT_W = 4;

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(PWM_LEVELS - 1);
    localparam logic [3:0]        FETCH_LAST = 4'(SCAN_COLS);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(SCAN_ROWS - 1);

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_FETCH = 2'd1,
        SCAN_BLANK = 2'd2,
        SCAN_SHOW  = 2'd3
    } scan_state_t;

    typedef logic [SCAN_COLS-1:0][PIX_W-1:0] line_buf_t;

    function automatic logic [SCAN_ROWS-1:0] row_onehot(
        input logic [ROW_W-1:0] idx
    );
        return SCAN_ROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/led_scan_pwm_col_cmp.sv
// Per-column PWM compare: a column sinks (0) while
// the current slot is below that pixel's value.
module led_scan_pwm_col_cmp
    import led_scan_pwm_pkg::*;
(
    input  logic [SLOT_W-1:0]    slot,
    input  line_buf_t            line_buf,
    output logic [SCAN_COLS-1:0] col_n
);

    // Value 0 is never lit, value 15 is lit in slots 0..14.
    always_comb begin
        col_n = '1;
        for (int j = 0; j < SCAN_COLS; j++) begin
            col_n[j] = !(slot < line_buf[j]);
        end
    end

endmodule

// File: rtl/led_scan_pwm.sv
// Row-multiplexed 8x8 LED scan driver with
// 16-level PWM and one-hot display RAM fetch.
module led_scan_pwm
    import led_scan_pwm_pkg::*;
#(
    parameter int SLOT_CYCLES  = SLOT_CYCLES_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [PIX_W-1:0]     led_data,
    output logic [SCAN_ROWS-1:0] rd_row,
    output logic [SCAN_COLS-1:0] rd_col,
    output logic [SCAN_ROWS-1:0] row_out,
    output logic [SCAN_COLS-1:0] col_out,
    output logic [ROW_W-1:0]     scan_row,
    output logic                 frame_start
);

    localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ?
                             SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t         state;
    logic [CW-1:0]       cnt;
    logic [3:0]          fidx;
    logic [SLOT_W-1:0]   slot;
    line_buf_t           line_buf;
    logic [2:0]          widx;
    logic [SLOT_W-1:0]   cmp_slot;
    logic [SCAN_COLS-1:0] cmp_col_n;

    // Fetch cycle k stores the word addressed in cycle k-1.
    assign widx = 3'(fidx - 4'd1);

    // Compare against the slot about to start so col_out
    // can be registered exactly at the slot boundary.
    always_comb begin
        cmp_slot = '0;
        if (state == SCAN_SHOW) begin
            cmp_slot = slot + 4'd1;
        end
    end

    led_scan_pwm_col_cmp u_cmp (
        .slot     (cmp_slot),
        .line_buf (line_buf),
        .col_n    (cmp_col_n)
    );

    // Line buffer: written only while fetching, stable in SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_buf <= '0;
        end else if (en && state == SCAN_FETCH && fidx != 4'd0) begin
            line_buf[widx] <= led_data;
        end
    end

    // Scan FSM with registered RAM address and matrix drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN_IDLE;
            cnt         <= '0;
            fidx        <= '0;
            slot        <= '0;
            rd_row      <= 8'h01;
            rd_col      <= 8'h01;
            row_out     <= 8'h00;
            col_out     <= 8'hFF;
            scan_row    <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= SCAN_IDLE;
            cnt         <= '0;
            fidx        <= '0;
            slot        <= '0;
            rd_row      <= 8'h01;
            rd_col      <= 8'h01;
            row_out     <= 8'h00;
            col_out     <= 8'hFF;
            scan_row    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                SCAN_IDLE: begin
                    state       <= SCAN_FETCH;
                    fidx        <= '0;
                    scan_row    <= '0;
                    rd_row      <= 8'h01;
                    rd_col      <= 8'h01;
                    frame_start <= 1'b1;
                end
                SCAN_FETCH: begin
                    if (fidx == FETCH_LAST) begin
                        state <= SCAN_BLANK;
                        cnt   <= '0;
                    end else begin
                        fidx <= fidx + 4'd1;
                        if (fidx < 4'd7) begin
                            rd_col <= rd_col << 1;
                        end
                    end
                end
                SCAN_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state   <= SCAN_SHOW;
                        cnt     <= '0;
                        slot    <= '0;
                        row_out <= row_onehot(scan_row);
                        col_out <= cmp_col_n;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SCAN_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt <= '0;
                        if (slot == LAST_SLOT) begin
                            state       <= SCAN_FETCH;
                            fidx        <= '0;
                            row_out     <= 8'h00;
                            col_out     <= 8'hFF;
                            scan_row    <= scan_row + 3'd1;
                            rd_row      <= row_onehot(scan_row + 3'd1);
                            rd_col      <= 8'h01;
                            frame_start <= (scan_row == LAST_ROW);
                        end else begin
                            slot    <= slot + 4'd1;
                            col_out <= cmp_col_n;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= SCAN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_pwm.sv
// Directed bench for led_scan_pwm: scan walk, PWM
// duty per column, fetch handshake, en drop, async reset.
module tb_led_scan_pwm;

    localparam int ROW_P   = 1041;
    localparam int FRAME_P = 8 * ROW_P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] led_data;
    logic [7:0] rd_row;
    logic [7:0] rd_col;
    logic [7:0] row_out;
    logic [7:0] col_out;
    logic [2:0] scan_row;
    logic       frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] mem [8][8];

    int r, p, slot, nfs;
    int fs_t [2];
    int lowcnt [8];
    int exp_low [8];
    int bad_fs, bad_scan, bad_rd, bad_row, bad_col;
    logic [7:0] exp_row;
    logic [7:0] exp_col;
    logic       exp_fs;

    always #5 clk = ~clk;

    led_scan_pwm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .led_data    (led_data),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .row_out     (row_out),
        .col_out     (col_out),
        .scan_row    (scan_row),
        .frame_start (frame_start)
    );

    function automatic int oh_idx(input logic [7:0] v);
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) k = i;
        end
        return k;
    endfunction

    // Display RAM model: registered read, one-cycle latency.
    always @(posedge clk) begin
        led_data <= mem[oh_idx(rd_row)][oh_idx(rd_col)];
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) mem[i][j] = 4'd0;
            lowcnt[i] = 0;
        end
        mem[2] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd15, 4'd15, 4'd0};
        mem[6] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd1};
        exp_low = '{0, 64, 128, 256, 512, 960, 960, 0};
        nfs = 0;
        fs_t = '{0, 0};
        bad_fs = 0; bad_scan = 0; bad_rd = 0; bad_row = 0; bad_col = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_row_out", row_out, 8'h00);
        chk("rst_col_out", col_out, 8'hFF);
        chk("rst_rd_row", rd_row, 8'h01);
        chk("rst_rd_col", rd_col, 8'h01);
        chk("rst_scan_row", scan_row, 3'd0);
        chk("rst_frame_start", frame_start, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_fs", frame_start, 1'b0);
        en = 1'b1;

        // Two full frames, sampled every cycle
        for (int i = 0; i < 2 * FRAME_P; i++) begin
            @(negedge clk);
            r = (i / ROW_P) % 8;
            p = i % ROW_P;
            exp_fs = ((i % FRAME_P) == 0);
            if (frame_start !== exp_fs) bad_fs++;
            if (frame_start === 1'b1) begin
                if (nfs < 2) fs_t[nfs] = i;
                nfs++;
            end
            if (scan_row !== 3'(r)) bad_scan++;
            exp_row = 8'h00;
            exp_col = 8'hFF;
            if (p < 9) begin
                if (rd_row !== 8'(1 << r)) bad_rd++;
                if (p < 8 && rd_col !== 8'(1 << p)) bad_rd++;
            end else if (p >= 17) begin
                slot = (p - 17) / 64;
                exp_row = 8'(1 << r);
                for (int j = 0; j < 8; j++) begin
                    exp_col[j] = !(int'(mem[r][j]) > slot);
                end
            end
            if (row_out !== exp_row) bad_row++;
            if (col_out !== exp_col) bad_col++;
            if (i < FRAME_P && row_out == 8'h04) begin
                for (int j = 0; j < 8; j++) begin
                    if (!col_out[j]) lowcnt[j]++;
                end
            end
            if (i < ROW_P && p < 8) chk("rd_col_seq", rd_col, 1 << p);
            if (i < FRAME_P && p == 17) chk("row_walk", row_out, 1 << r);
        end
        chk("frame_start_cycles", bad_fs, 0);
        chk("scan_row_cycles", bad_scan, 0);
        chk("rd_addr_cycles", bad_rd, 0);
        chk("row_out_cycles", bad_row, 0);
        chk("col_out_cycles", bad_col, 0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("row2_low_col%0d", j), lowcnt[j], exp_low[j]);
        end
        chk("fs_count", nfs, 2);
        chk("fs_spacing", fs_t[1] - fs_t[0], FRAME_P);

        // en drop mid-SHOW of row 5 in the third frame
        repeat (5 * ROW_P + 17 + 500) @(negedge clk);
        chk("row5_lit", row_out, 8'h20);
        chk("row5_scan", scan_row, 3'd5);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_row", row_out, 8'h00);
        chk("en_off_col", col_out, 8'hFF);
        chk("en_off_scan", scan_row, 3'd0);
        chk("en_off_fs", frame_start, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("reen_fs", frame_start, 1'b1);
        chk("reen_scan", scan_row, 3'd0);
        chk("reen_rd_row", rd_row, 8'h01);
        chk("reen_rd_col", rd_col, 8'h01);
        @(negedge clk);
        chk("reen_fs_one_cycle", frame_start, 1'b0);

        // Async reset mid-SHOW of row 0
        repeat (116) @(negedge clk);
        chk("row0_lit", row_out, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row_out", row_out, 8'h00);
        chk("arst_col_out", col_out, 8'hFF);
        chk("arst_scan_row", scan_row, 3'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle_row", row_out, 8'h00);
        chk("post_rst_idle_fs", frame_start, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("post_rst_fs", frame_start, 1'b1);
        chk("post_rst_rd_row", rd_row, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
